// File: rtl/mem_port_if.sv
// Bundle of the fetch, load/store and RAM-side signals around mem_port_arbiter.
//   slave  : the arbiter's view (requests and mem_rdata in; grants, responses, mem_* out)
//   master : the view of the core/RAM side that drives requests and observes responses
interface mem_port_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   logic [2:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
             mem_we, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
             mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-addressed, big-endian data RAM between the
// instruction-fetch port and the load/store port. One grant per cycle, grants are
// combinational, responses come back registered one cycle after the grant.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_port_if.slave: i_* fetch port, d_* LSU port, mem_* RAM port
//
// Build option:
//   MEM_ARB_RR_EN defined   - round-robin on ties (tie goes to the port that did not win last)
//   MEM_ARB_RR_EN undefined - LSU wins ties; fetch is forced through after MAX_WAIT lost ties
module mem_port_arbiter #(
   parameter int MEM_BYTES = 2048,
   parameter int MAX_WAIT  = 4
) (
   input logic       clk,
   input logic       rst,
   mem_port_if.slave bus
);

   logic        i_gnt_c;
   logic        d_gnt_c;
   logic        tie_fetch;
   logic [2:0]  d_nbytes;
   logic [32:0] d_end;
   logic        d_misalign;
   logic        d_err_c;
   logic        d_store_ok;
   logic [2:0]  st_we;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

   logic        i_rvalid_q;
   logic [31:0] i_rdata_q;
   logic        d_rvalid_q;
   logic        d_err_q;
   logic [31:0] d_rdata_q;

   // Size decode: store lane formatting, load extension and access length.
   always_comb begin
      d_nbytes = 3'd4;
      st_we    = 3'b000;
      st_wdata = '0;
      ld_data  = bus.mem_rdata;
      case (bus.d_size)
         2'd0: begin
            d_nbytes = 3'd1;
            st_we    = 3'b100;
            st_wdata = {24'h0, bus.d_wdata[7:0]};
            ld_data  = {{24{~bus.d_unsigned & bus.mem_rdata[31]}}, bus.mem_rdata[31:24]};
         end
         2'd1: begin
            d_nbytes = 3'd2;
            st_we    = 3'b010;
            st_wdata = {16'h0, bus.d_wdata[15:0]};
            ld_data  = {{16{~bus.d_unsigned & bus.mem_rdata[31]}}, bus.mem_rdata[31:16]};
         end
         2'd2: begin
            st_we    = 3'b001;
            st_wdata = bus.d_wdata;
         end
         default: ;
      endcase
   end

   // 33-bit end address so an access near 0xFFFFFFFF cannot wrap back into range.
   assign d_end      = {1'b0, bus.d_addr} + {30'd0, d_nbytes};
   assign d_misalign = ((bus.d_size == 2'd1) && bus.d_addr[0]) ||
                       ((bus.d_size == 2'd2) && (bus.d_addr[1:0] != 2'b00));
   assign d_err_c    = (bus.d_size == 2'd3) || d_misalign || (d_end > 33'(MEM_BYTES));

`ifdef MEM_ARB_RR_EN
   logic last_lsu;

   assign tie_fetch = last_lsu;

   always_ff @(posedge clk) begin
      if (rst)
         last_lsu <= 1'b1;
      else if (i_gnt_c || d_gnt_c)
         last_lsu <= d_gnt_c;
   end
`else
   localparam int WCW = $clog2(MAX_WAIT + 1);

   logic [WCW-1:0] wait_cnt;

   assign tie_fetch = (wait_cnt == WCW'(MAX_WAIT));

   // Counts consecutive cycles in which a pending fetch lost to the LSU.
   always_ff @(posedge clk) begin
      if (rst)
         wait_cnt <= '0;
      else if (!bus.i_req || i_gnt_c)
         wait_cnt <= '0;
      else if (!tie_fetch)
         wait_cnt <= wait_cnt + 1'b1;
   end
`endif

   // No grants while reset is held, so nothing is issued that would be dropped.
   assign i_gnt_c    = ~rst & bus.i_req & (~bus.d_req | tie_fetch);
   assign d_gnt_c    = ~rst & bus.d_req & ~i_gnt_c;
   assign d_store_ok = d_gnt_c & bus.d_we & ~d_err_c;

   assign bus.i_gnt     = i_gnt_c;
   assign bus.d_gnt     = d_gnt_c;
   assign bus.mem_addr  = i_gnt_c ? bus.i_addr : bus.d_addr;
   assign bus.mem_we    = d_store_ok ? st_we : 3'b000;
   assign bus.mem_wdata = d_store_ok ? st_wdata : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         i_rvalid_q <= 1'b0;
         i_rdata_q  <= '0;
         d_rvalid_q <= 1'b0;
         d_err_q    <= 1'b0;
         d_rdata_q  <= '0;
      end else begin
         i_rvalid_q <= i_gnt_c;
         i_rdata_q  <= i_gnt_c ? bus.mem_rdata : 32'h0;
         d_rvalid_q <= d_gnt_c;
         d_err_q    <= d_gnt_c & d_err_c;
         d_rdata_q  <= (d_gnt_c && !bus.d_we && !d_err_c) ? ld_data : 32'h0;
      end
   end

   // A reset in the cycle after a grant kills that grant's response immediately.
   assign bus.i_rvalid = i_rvalid_q & ~rst;
   assign bus.i_rdata  = i_rdata_q;
   assign bus.d_rvalid = d_rvalid_q & ~rst;
   assign bus.d_err    = d_err_q & ~rst;
   assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int MEM_BYTES = 2048;
   localparam int MAX_WAIT  = 4;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   mem_port_if bus();

   mem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .MAX_WAIT(MAX_WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Bench RAM, written from the DUT's mem_* outputs, read combinationally.
   logic [7:0]  ram     [MEM_BYTES];
   logic [7:0]  ref_mem [MEM_BYTES];
   logic [31:0] mem_rd;

   always_comb begin
      mem_rd = '0;
      for (int k = 0; k < 4; k++) begin
         if (longint'(bus.mem_addr) + longint'(k) < longint'(MEM_BYTES))
            mem_rd[8*(3-k) +: 8] = ram[int'(longint'(bus.mem_addr) + longint'(k))];
      end
   end
   assign bus.mem_rdata = mem_rd;

   int errors = 0;
   int checks = 0;

   // reference model state
   int          losses;
   bit          last_lsu_m;
   bit          exp_i_rv, exp_d_rv, exp_d_err;
   logic [31:0] exp_i_rd, exp_d_rd;
   bit          m_rst, m_fetch, m_lsu, m_store_ok, m_i_req;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] n_i_rd, n_d_rd;
   bit          n_d_err;
   logic [2:0]  s_we;
   logic [31:0] s_addr, s_wdata;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  exp_we;
      logic [31:0] exp_wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_rd32(logic [31:0] a);
      logic [31:0] r = '0;
      for (int k = 0; k < 4; k++) begin
         longint ea = longint'(a) + longint'(k);
         if (ea < longint'(MEM_BYTES))
            r = r | (32'(ref_mem[int'(ea)]) << (8 * (3 - k)));
      end
      return r;
   endfunction

   function automatic bit ref_err(logic [1:0] size, logic [31:0] addr);
      longint nb, a;
      if (size == 2'd3) return 1'b1;
      nb = longint'(1) << size;
      a  = longint'(addr);
      return ((a % nb) != 0) || (a + nb > longint'(MEM_BYTES));
   endfunction

   function automatic logic [31:0] ref_load(logic [1:0] size, logic uns, logic [31:0] addr);
      logic [31:0] v = ref_rd32(addr);
      longint x;
      int w;
      if (size == 2'd2) return v;
      w = (size == 2'd0) ? 8 : 16;
      x = longint'(v >> (32 - w));
      if (!uns && x >= (longint'(1) << (w - 1)))
         x = x - (longint'(1) << w);
      return 32'(x);
   endfunction

   function automatic logic [31:0] ref_store_data(logic [1:0] size, logic [31:0] wd);
      if (size == 2'd0) return wd & 32'hFF;
      if (size == 2'd1) return wd & 32'hFFFF;
      return wd;
   endfunction

   task automatic model_check();
      bit          err;
      logic [2:0]  exp_we;
      chk("i_rvalid", 32'(bus.i_rvalid), 32'(exp_i_rv && !rst));
      if (exp_i_rv && !rst) chk("i_rdata", bus.i_rdata, exp_i_rd);
      chk("d_rvalid", 32'(bus.d_rvalid), 32'(exp_d_rv && !rst));
      if (exp_d_rv && !rst) begin
         chk("d_err", 32'(bus.d_err), 32'(exp_d_err));
         chk("d_rdata", bus.d_rdata, exp_d_rd);
      end
      m_rst   = rst;
      m_fetch = 1'b0;
      m_lsu   = 1'b0;
      if (!rst) begin
         if (bus.i_req && bus.d_req)
            m_fetch = RR ? last_lsu_m : (losses >= MAX_WAIT);
         else
            m_fetch = bus.i_req;
         m_lsu = bus.d_req && !m_fetch;
      end
      err        = ref_err(bus.d_size, bus.d_addr);
      m_store_ok = m_lsu && bus.d_we && !err;
      exp_we     = !m_store_ok ? 3'b000 : (bus.d_size == 2'd2) ? 3'b001 :
                   (bus.d_size == 2'd1) ? 3'b010 : 3'b100;
      chk("i_gnt", 32'(bus.i_gnt), 32'(m_fetch));
      chk("d_gnt", 32'(bus.d_gnt), 32'(m_lsu));
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
      if (m_fetch) chk("mem_addr_i", bus.mem_addr, bus.i_addr);
      if (m_lsu)   chk("mem_addr_d", bus.mem_addr, bus.d_addr);
      if (m_store_ok) chk("mem_wdata", bus.mem_wdata, ref_store_data(bus.d_size, bus.d_wdata));
      n_i_rd  = ref_rd32(bus.i_addr);
      n_d_err = m_lsu && err;
      n_d_rd  = (m_lsu && !bus.d_we && !err) ? ref_load(bus.d_size, bus.d_unsigned, bus.d_addr) : 32'h0;
      m_i_req = bus.i_req;
      m_size  = bus.d_size;
      m_addr  = bus.d_addr;
      m_wdata = bus.d_wdata;
      s_we    = bus.mem_we;
      s_addr  = bus.mem_addr;
      s_wdata = bus.mem_wdata;
   endtask

   task automatic model_update();
      int nb;
      if (m_rst) begin
         exp_i_rv   = 1'b0;
         exp_d_rv   = 1'b0;
         exp_d_err  = 1'b0;
         losses     = 0;
         last_lsu_m = 1'b1;
      end else begin
         exp_i_rv  = m_fetch;
         exp_i_rd  = n_i_rd;
         exp_d_rv  = m_lsu;
         exp_d_err = n_d_err;
         exp_d_rd  = n_d_rd;
         if (m_store_ok) begin
            nb = 1 << m_size;
            for (int k = 0; k < nb; k++)
               ref_mem[int'(longint'(m_addr) + longint'(k))] = 8'(m_wdata >> (8 * (nb - 1 - k)));
         end
         losses = (!m_i_req || m_fetch) ? 0 : losses + 1;
         if (m_fetch || m_lsu) last_lsu_m = m_lsu;
      end
      nb = (s_we == 3'b001) ? 4 : (s_we == 3'b010) ? 2 : (s_we == 3'b100) ? 1 : 0;
      for (int k = 0; k < nb; k++) begin
         longint ea = longint'(s_addr) + longint'(k);
         if (ea < longint'(MEM_BYTES))
            ram[int'(ea)] = 8'(s_wdata >> (8 * (nb - 1 - k)));
      end
   endtask

   task automatic half_a();
      @(negedge clk);
      model_check();
   endtask

   task automatic half_b();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic tick();
      half_a();
      half_b();
   endtask

   task automatic set_d(logic we, logic [1:0] size, logic uns, logic [31:0] addr, logic [31:0] wd);
      bus.d_req      = 1'b1;
      bus.d_we       = we;
      bus.d_size     = size;
      bus.d_unsigned = uns;
      bus.d_addr     = addr;
      bus.d_wdata    = wd;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      bit ip, dp;
      int bad;

      vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h21,       32'h1FF,      3'b100, 32'hFF,       1'b0, 32'h0};
      vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h21,       32'h0,        3'b000, 32'h0,        1'b0, 32'hFFFFFFFF};
      vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h21,       32'h0,        3'b000, 32'h0,        1'b0, 32'h000000FF};
      vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h40,       32'h12345678, 3'b001, 32'h12345678, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h40,       32'h0,        3'b000, 32'h0,        1'b0, 32'h12345678};
      vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h42,       32'h0,        3'b000, 32'h0,        1'b0, 32'h00005678};
      vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h43,       32'h0,        3'b000, 32'h0,        1'b0, 32'h00000078};
      vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h44,       32'hABCD8001, 3'b010, 32'h00008001, 1'b0, 32'h0};
      vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h44,       32'h0,        3'b000, 32'h0,        1'b0, 32'hFFFF8001};
      vecs[9]  = '{1'b0, 2'd1, 1'b1, 32'h44,       32'h0,        3'b000, 32'h0,        1'b0, 32'h00008001};
      vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h02,       32'hFFFFFFFF, 3'b000, 32'h0,        1'b1, 32'h0};
      vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h7FF,      32'h0,        3'b000, 32'h0,        1'b1, 32'h0};
      vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h7FC,      32'hCAFEF00D, 3'b001, 32'hCAFEF00D, 1'b0, 32'h0};
      vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h7FC,      32'h0,        3'b000, 32'h0,        1'b0, 32'hCAFEF00D};
      vecs[14] = '{1'b1, 2'd0, 1'b0, 32'h7FF,      32'h12345680, 3'b100, 32'h80,       1'b0, 32'h0};
      vecs[15] = '{1'b0, 2'd0, 1'b0, 32'h7FF,      32'h0,        3'b000, 32'h0,        1'b0, 32'hFFFFFF80};
      vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h7FC,      32'h0,        3'b000, 32'h0,        1'b0, 32'hCAFEF080};
      vecs[17] = '{1'b0, 2'd1, 1'b0, 32'h7FE,      32'h0,        3'b000, 32'h0,        1'b0, 32'hFFFFF080};
      vecs[18] = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,        3'b000, 32'h0,        1'b1, 32'h0};
      vecs[19] = '{1'b0, 2'd3, 1'b0, 32'h0,        32'h0,        3'b000, 32'h0,        1'b1, 32'h0};
      vecs[20] = '{1'b0, 2'd2, 1'b0, 32'h800,      32'h0,        3'b000, 32'h0,        1'b1, 32'h0};
      vecs[21] = '{1'b0, 2'd0, 1'b0, 32'h800,      32'h0,        3'b000, 32'h0,        1'b1, 32'h0};
      vecs[22] = '{1'b0, 2'd1, 1'b0, 32'h01,       32'h0,        3'b000, 32'h0,        1'b1, 32'h0};

      for (int k = 0; k < MEM_BYTES; k++) begin
         logic [7:0] b = 8'($urandom);
         ram[k]     = b;
         ref_mem[k] = b;
      end
      ram[16'h10] = 8'hDE; ram[16'h11] = 8'hAD; ram[16'h12] = 8'hBE; ram[16'h13] = 8'hEF;
      ref_mem[16'h10] = 8'hDE; ref_mem[16'h11] = 8'hAD; ref_mem[16'h12] = 8'hBE; ref_mem[16'h13] = 8'hEF;

      losses = 0; last_lsu_m = 1'b1;
      exp_i_rv = 1'b0; exp_d_rv = 1'b0; exp_d_err = 1'b0; exp_i_rd = '0; exp_d_rd = '0;
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_unsigned = 1'b0;
      bus.d_addr = '0; bus.d_wdata = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // single fetch
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      half_a();
      chk("t1_i_gnt", 32'(bus.i_gnt), 32'h1);
      half_b();
      bus.i_req = 1'b0;
      half_a();
      chk("t1_i_rvalid", 32'(bus.i_rvalid), 32'h1);
      chk("t1_i_rdata", bus.i_rdata, 32'hDEADBEEF);
      half_b();

      // LSU vector table: grant cycle, then response cycle
      for (int v = 0; v < NV; v++) begin
         set_d(vecs[v].we, vecs[v].size, vecs[v].uns, vecs[v].addr, vecs[v].wdata);
         half_a();
         chk("tab_d_gnt", 32'(bus.d_gnt), 32'h1);
         chk("tab_mem_we", 32'(bus.mem_we), 32'(vecs[v].exp_we));
         if (vecs[v].exp_we != 3'b000) chk("tab_mem_wdata", bus.mem_wdata, vecs[v].exp_wdata);
         half_b();
         bus.d_req = 1'b0;
         half_a();
         chk("tab_d_rvalid", 32'(bus.d_rvalid), 32'h1);
         chk("tab_d_err", 32'(bus.d_err), 32'(vecs[v].exp_err));
         chk("tab_d_rdata", bus.d_rdata, vecs[v].exp_rdata);
         half_b();
      end

      // store then load back to back
      set_d(1'b1, 2'd2, 1'b0, 32'h80, 32'h55AA33CC);
      tick();
      set_d(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
      tick();
      bus.d_req = 1'b0;
      half_a();
      chk("t5_d_rdata", bus.d_rdata, 32'h55AA33CC);
      half_b();

      // continuous tie
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      set_d(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      for (int k = 0; k < 15; k++) begin
         half_a();
         chk("t3_tie_i_gnt", 32'(bus.i_gnt), 32'(RR ? (k % 2 == 0) : (k % 5 == 4)));
         half_b();
      end

      // reset right after a grant
      do_reset();
      tick();
      tick();
      tick();
      rst = 1'b1;
      half_a();
      chk("t6_i_rvalid", 32'(bus.i_rvalid), 32'h0);
      chk("t6_d_rvalid", 32'(bus.d_rvalid), 32'h0);
      half_b();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         half_a();
         chk("t6_tie_i_gnt", 32'(bus.i_gnt), 32'(RR ? (k % 2 == 0) : (k == 4)));
         half_b();
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      tick();

      // randomized traffic against the model
      ip = 1'b0; dp = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1'b1;
            bus.i_addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 511) * 4);
         end else if (ip && $urandom_range(0, 15) == 0) begin
            ip = 1'b0;
         end
         if (!dp && $urandom_range(0, 1) == 0) begin
            logic [1:0] sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
               6:       a = 32'($urandom_range(2040, 2052));
               7:       a = $urandom;
               default: a = 32'($urandom_range(0, 2047)) & ~((32'h1 << sz) - 1);
            endcase
            dp = 1'b1;
            set_d(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
         end else if (dp && $urandom_range(0, 15) == 0) begin
            dp = 1'b0;
         end
         bus.i_req = ip;
         bus.d_req = dp;
         rst = ($urandom_range(0, 149) == 0);
         tick();
         if (m_fetch) ip = 1'b0;
         if (m_lsu)   dp = 1'b0;
      end
      rst = 1'b0;
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      tick();
      tick();

      bad = 0;
      for (int k = 0; k < MEM_BYTES; k++)
         if (ram[k] !== ref_mem[k]) bad++;
      chk("ram_image_bad_bytes", 32'(bad), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
